vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port 64KB VRAM (32K x 16 words) between the PPU fetch engine and the CPU.
- Accepts at most one access per clock using valid/ready handshakes.
- PPU has priority during active display; a starvation counter guarantees CPU forward progress.
- Registers all memory-side signals and returns read data to the requester that issued the read.

Parameters:
- ADDR_W, 15, VRAM word-address width.
- DATA_W, 16, data width.
- STARVE_MAX, 4, consecutive blocked CPU cycles before the CPU is forced to win; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ppu_active  in  1  1 = active display (PPU priority); 0 = blanking (CPU priority)
- ppu_req  in  1  PPU request valid
- ppu_we  in  1  PPU write (1) / read (0)
- ppu_addr  in  ADDR_W  PPU word address
- ppu_wdata  in  DATA_W  PPU write data
- ppu_gnt  out  1  PPU request accepted this cycle (combinational)
- ppu_rvalid  out  1  PPU read data valid
- ppu_rdata  out  DATA_W  PPU read data
- cpu_req  in  1  CPU request valid
- cpu_we  in  1  CPU write / read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU request accepted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- mem_en  out  1  VRAM access strobe (registered)
- mem_we  out  1  VRAM write enable (registered)
- mem_addr  out  ADDR_W  VRAM word address (registered)
- mem_wdata  out  DATA_W  VRAM write data (registered)
- mem_rdata  in  DATA_W  VRAM read data; valid the cycle after mem_en is sampled (synchronous RAM)

Behaviour:
- Reset (async, reset_n low): every output is 0, including gnt, rvalid, rdata and all mem_* outputs. The starvation counter and the read-return pipeline are cleared. Reads in flight when reset asserts are discarded and produce no rvalid after reset releases.
- Handshake:
  - A transfer occurs at a clock edge where req && gnt.
  - The requester holds req, we, addr and wdata stable until it is granted.
  - gnt is asserted for at most one requester per cycle and never without that requester's req.
- Selection, each cycle:
  - Only one request: it wins.
  - Both request and starve_cnt == STARVE_MAX: CPU wins.
  - Both request, ppu_active = 1: PPU wins.
  - Both request, ppu_active = 0: CPU wins.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, each cycle cpu_req = 1 and cpu_gnt = 0.
  - Clears on CPU acceptance or when cpu_req = 0.
  - Width: clog2(STARVE_MAX + 1).
- Issue: at the accepting edge, mem_en = 1 and mem_we/addr/wdata take the winner's values. With no acceptance, mem_en = 0 and mem_we = 0; mem_addr and mem_wdata hold their previous values.
- Read return:
  - A 2-stage owner tag (valid, is_cpu) tracks each accepted read.
  - Read latency is 2 cycles: acceptance at edge E0, memory samples at E1, the arbiter registers mem_rdata into <owner>_rdata with <owner>_rvalid = 1 at E2.
  - rvalid is a single-cycle pulse. rdata holds its value until the next read for the same owner.
  - Writes never produce rvalid.
- Throughput: one access per cycle sustained. Back-to-back reads from either or both owners pipeline without bubbles.
- Ordering: accesses reach VRAM in acceptance order. A read accepted after a write to the same address returns the new data.
- Address width: no wrap or translation; the address is passed through unchanged.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- When defined, adds output stat_cpu_stall (16-bit) counting cycles with cpu_req = 1 and cpu_gnt = 0. The counter saturates at 16'hFFFF and is cleared by reset, and additionally by a 1-cycle input pulse stat_clr, which has priority over the increment.
- When not defined, stat_cpu_stall and stat_clr do not exist and no counter logic is present.

Test Plan:
- Reset: pulse reset_n low mid-stream with 2 reads in flight -> all outputs 0 during reset; no rvalid in the 3 cycles after release.
- PPU read of 0x0123 (VRAM holds 0xBEEF), CPU idle -> ppu_gnt same cycle; mem_en/mem_addr = 0x0123 next cycle; ppu_rvalid = 1 with ppu_rdata = 0xBEEF 2 cycles after acceptance.
- ppu_active = 1, both requesting continuously, STARVE_MAX = 4 -> grant pattern PPU x4, CPU x1, repeating; CPU gets exactly 1 grant per 5 cycles.
- ppu_active = 0, both requesting -> CPU granted every cycle; ppu_gnt stays 0; starve_cnt stays 0.
- CPU write 0x5A5A to 0x7FFF, then PPU read of 0x7FFF next cycle -> ppu_rdata = 0x5A5A; cpu_rvalid never asserts.
- VRAM_ARB_STATS_EN defined: CPU blocked 10 cycles, then stat_clr pulse -> stat_cpu_stall = 10, then 0 the cycle after stat_clr.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port synchronous VRAM between the PPU fetch engine and the CPU.
// Optional macro VRAM_ARB_STATS_EN adds a saturating CPU stall-cycle counter (stat_cpu_stall, stat_clr).
module vram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ppu_active,
    input  logic              ppu_req,
    input  logic              ppu_we,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic [DATA_W-1:0] ppu_wdata,
    output logic              ppu_gnt,
    output logic              ppu_rvalid,
    output logic [DATA_W-1:0] ppu_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
`ifdef VRAM_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_cpu_stall,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [SC_W-1:0] starve_cnt;
    logic            starved;
    logic            cpu_win;
    logic            ppu_win;
    logic            accept;
    logic            sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic rd_v1, rd_cpu1;
    logic rd_v2, rd_cpu2;

    assign starved = (starve_cnt == SC_W'(STARVE_MAX));

    // CPU wins when alone, when starved, or during blanking; PPU takes everything else
    always_comb begin
        cpu_win = 1'b0;
        ppu_win = 1'b0;
        if (cpu_req && (!ppu_req || starved || !ppu_active)) begin
            cpu_win = 1'b1;
        end else if (ppu_req) begin
            ppu_win = 1'b1;
        end
    end

    // Grants are forced low while reset is held so no handshake can complete
    assign cpu_gnt = cpu_win & reset_n;
    assign ppu_gnt = ppu_win & reset_n;
    assign accept  = cpu_win | ppu_win;

    always_comb begin
        sel_we    = ppu_we;
        sel_addr  = ppu_addr;
        sel_wdata = ppu_wdata;
        if (cpu_win) begin
            sel_we    = cpu_we;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (cpu_req && !cpu_win) begin
            if (!starved) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // mem_addr/mem_wdata hold across idle cycles; only the strobes drop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= accept;
            mem_we <= accept & sel_we;
            if (accept) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_v1   <= 1'b0;
            rd_cpu1 <= 1'b0;
            rd_v2   <= 1'b0;
            rd_cpu2 <= 1'b0;
        end else begin
            rd_v1   <= accept & ~sel_we;
            rd_cpu1 <= cpu_win;
            rd_v2   <= rd_v1;
            rd_cpu2 <= rd_cpu1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ppu_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            ppu_rdata  <= '0;
            cpu_rdata  <= '0;
        end else begin
            ppu_rvalid <= rd_v2 & ~rd_cpu2;
            cpu_rvalid <= rd_v2 & rd_cpu2;
            if (rd_v2 && !rd_cpu2) begin
                ppu_rdata <= mem_rdata;
            end
            if (rd_v2 && rd_cpu2) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

`ifdef VRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_cpu_stall <= '0;
        end else if (stat_clr) begin
            stat_cpu_stall <= '0;
        end else if (cpu_req && !cpu_win && (stat_cpu_stall != 16'hFFFF)) begin
            stat_cpu_stall <= stat_cpu_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural grant/memory model with per-cycle compare, directed and random stimulus.
// Define VRAM_ARB_STATS_EN to also exercise the stall statistics counter.
module tb_vram_arbiter;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int SM = 4;

    logic          clk;
    logic          reset_n;
    logic          ppu_active;
    logic          ppu_req, ppu_we, cpu_req, cpu_we;
    logic [AW-1:0] ppu_addr, cpu_addr;
    logic [DW-1:0] ppu_wdata, cpu_wdata;
    logic          ppu_gnt, cpu_gnt, ppu_rvalid, cpu_rvalid;
    logic [DW-1:0] ppu_rdata, cpu_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef VRAM_ARB_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_cpu_stall;
`endif

    int checks = 0;
    int errors = 0;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset_n(reset_n), .ppu_active(ppu_active),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
        .ppu_gnt(ppu_gnt), .ppu_rvalid(ppu_rvalid), .ppu_rdata(ppu_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
`ifdef VRAM_ARB_STATS_EN
        .stat_clr(stat_clr), .stat_cpu_stall(stat_cpu_stall),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous single-port VRAM
    logic [DW-1:0] vram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata <= vram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int            due;
        bit            is_cpu;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rq[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int            cyc = 0;
    int            blocked = 0;
    logic          x_en, x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata, x_prd, x_crd;

    always @(negedge clk) begin
        bit e_cpu, e_ppu, e_prv, e_crv, w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        cyc++;
        if (!reset_n) begin
            rq.delete();
            blocked = 0;
            x_en = 0; x_we = 0; x_addr = '0; x_wdata = '0; x_prd = '0; x_crd = '0;
        end else begin
            e_cpu = cpu_req && (!ppu_req || blocked >= SM || !ppu_active);
            e_ppu = ppu_req && !e_cpu;
            e_prv = 0; e_crv = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                if (rq[0].is_cpu) begin e_crv = 1; x_crd = rq[0].data; end
                else              begin e_prv = 1; x_prd = rq[0].data; end
                void'(rq.pop_front());
            end
            chk("ppu_gnt", ppu_gnt, e_ppu);
            chk("cpu_gnt", cpu_gnt, e_cpu);
            chk("mem_en", mem_en, x_en);
            chk("mem_we", mem_we, x_we);
            chk("mem_addr", mem_addr, x_addr);
            chk("mem_wdata", mem_wdata, x_wdata);
            chk("ppu_rvalid", ppu_rvalid, e_prv);
            chk("cpu_rvalid", cpu_rvalid, e_crv);
            chk("ppu_rdata", ppu_rdata, x_prd);
            chk("cpu_rdata", cpu_rdata, x_crd);
            if (e_cpu || e_ppu) begin
                w = e_cpu ? cpu_we : ppu_we;
                a = e_cpu ? cpu_addr : ppu_addr;
                d = e_cpu ? cpu_wdata : ppu_wdata;
                x_en = 1; x_we = w; x_addr = a; x_wdata = d;
                if (w) shadow[a] = d;
                else   rq.push_back('{due: cyc + 3, is_cpu: e_cpu, data: shadow[a]});
            end else begin
                x_en = 0; x_we = 0;
            end
            if (cpu_req && !e_cpu) blocked = (blocked < SM) ? blocked + 1 : SM;
            else                   blocked = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        ppu_req = 0; cpu_req = 0;
        repeat (n) step();
    endtask

    logic [9:0] pv, cv;
    logic [7:0] pv8, cv8;
    bit         prv_seen, crv_seen;
    logic [DW-1:0] prd_seen;
    bit         pg, cg;

    initial begin
        reset_n = 0; ppu_active = 1;
        ppu_req = 0; ppu_we = 0; ppu_addr = '0; ppu_wdata = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
`ifdef VRAM_ARB_STATS_EN
        stat_clr = 0;
`endif
        for (int i = 0; i < (1<<AW); i++) begin
            vram[i]   = DW'(i * 7) ^ 16'h3C5A;
            shadow[i] = DW'(i * 7) ^ 16'h3C5A;
        end
        vram[15'h0123] = 16'hBEEF; shadow[15'h0123] = 16'hBEEF;
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ppu_rdata", ppu_rdata, 0);
        repeat (2) step();
        reset_n = 1;
        step();

        // single PPU read
        ppu_req = 1; ppu_we = 0; ppu_addr = 15'h0123;
        @(negedge clk); chk("t1_ppu_gnt", ppu_gnt, 1);
        step(); ppu_req = 0;
        @(negedge clk); chk("t1_mem_en", mem_en, 1); chk("t1_mem_addr", mem_addr, 15'h0123);
        @(negedge clk);
        @(negedge clk); chk("t1_rvalid", ppu_rvalid, 1); chk("t1_rdata", ppu_rdata, 16'hBEEF);
        idle(3);

        // starvation pattern during active display
        ppu_active = 1; ppu_req = 1; cpu_req = 1; ppu_we = 0; cpu_we = 0;
        ppu_addr = 15'd100; cpu_addr = 15'd200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); pv[i] = ppu_gnt; cv[i] = cpu_gnt;
            step();
            if (pv[i]) ppu_addr = ppu_addr + 1;
            if (cv[i]) cpu_addr = cpu_addr + 1;
        end
        chk("t2_cpu_pattern", cv, 10'b1000010000);
        chk("t2_ppu_pattern", pv, 10'b0111101111);
        idle(4);

        // blanking: CPU wins every cycle
        ppu_active = 0; ppu_req = 1; cpu_req = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); pv8[i] = ppu_gnt; cv8[i] = cpu_gnt;
            step();
            if (cv8[i]) cpu_addr = cpu_addr + 1;
        end
        chk("t3_cpu_all", cv8, 8'hFF);
        chk("t3_ppu_none", pv8, 8'h00);
        idle(4);
        ppu_active = 1;

        // CPU write then PPU read of same address
        cpu_req = 1; cpu_we = 1; cpu_addr = 15'h7FFF; cpu_wdata = 16'h5A5A;
        @(negedge clk); chk("t4_cpu_gnt", cpu_gnt, 1);
        step(); cpu_req = 0; cpu_we = 0;
        ppu_req = 1; ppu_we = 0; ppu_addr = 15'h7FFF;
        @(negedge clk); chk("t4_ppu_gnt", ppu_gnt, 1);
        step(); ppu_req = 0;
        prv_seen = 0; crv_seen = 0; prd_seen = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ppu_rvalid) begin prv_seen = 1; prd_seen = ppu_rdata; end
            if (cpu_rvalid) crv_seen = 1;
        end
        chk("t4_ppu_rv", prv_seen, 1);
        chk("t4_ppu_rdata", prd_seen, 16'h5A5A);
        chk("t4_no_cpu_rv", crv_seen, 0);
        idle(3);

`ifdef VRAM_ARB_STATS_EN
        stat_clr = 1; step(); stat_clr = 0;
        ppu_active = 1; ppu_req = 1; cpu_req = 1; ppu_we = 0; cpu_we = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); pg = ppu_gnt; cg = cpu_gnt;
            step();
            if (pg) ppu_addr = ppu_addr + 1;
            if (cg) cpu_addr = cpu_addr + 1;
        end
        ppu_req = 0; cpu_req = 0;
        @(negedge clk); chk("stat_10", stat_cpu_stall, 10);
        step(); stat_clr = 1; step(); stat_clr = 0;
        @(negedge clk); chk("stat_clr", stat_cpu_stall, 0);
        idle(3);
`endif

        // reset with two reads in flight
        ppu_req = 1; ppu_we = 0; ppu_addr = 15'd10;
        step(); ppu_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 15'd11;
        step(); reset_n = 0; ppu_req = 1; cpu_req = 1;
        #1;
        chk("rst_gnt", {ppu_gnt, cpu_gnt}, 0);
        chk("rst_rvalid", {ppu_rvalid, cpu_rvalid}, 0);
        chk("rst_rdata", {ppu_rdata, cpu_rdata}, 0);
        chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
`ifdef VRAM_ARB_STATS_EN
        chk("rst_stat", stat_cpu_stall, 0);
`endif
        repeat (2) step();
        reset_n = 1; ppu_req = 0; cpu_req = 0;
        prv_seen = 0; crv_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ppu_rvalid) prv_seen = 1;
            if (cpu_rvalid) crv_seen = 1;
        end
        chk("rst_no_rv_after", {prv_seen, crv_seen}, 0);
        step();

        // randomized traffic, holding requests until granted
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                idle(2);
                reset_n = 0; step(); step(); reset_n = 1;
            end
            @(negedge clk); pg = ppu_gnt; cg = cpu_gnt;
            step();
            if ((i % 64) == 0) ppu_active = $urandom_range(0, 1);
            if (!ppu_req || pg) begin
                ppu_req   = ($urandom_range(0, 9) < 7);
                ppu_we    = ($urandom_range(0, 3) == 0);
                ppu_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                ppu_wdata = DW'($urandom);
            end
            if (!cpu_req || cg) begin
                cpu_req   = ($urandom_range(0, 9) < 6);
                cpu_we    = ($urandom_range(0, 1) == 0);
                cpu_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                cpu_wdata = DW'($urandom);
            end
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
